// File: rtl/dequant_sched.sv
// Credit-gated round-robin scheduler for a fixed-latency dequantizer.
// Captures dequantizer results in issue order into a small output FIFO.
module dequant_sched #(
  parameter int LAT   = 5,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [31:0] w_level,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] a_level,
  output logic        dq_issue,
  output logic [31:0] dq_level_int,
  output logic        dq_is_weight,
  input  logic [31:0] dq_result,
  input  logic        dq_ovfl,
  input  logic        dq_unfl,
  input  logic        dq_excp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_src,
  output logic [2:0]  out_flags,
  output logic [15:0] err_count,
  output logic        busy
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0] data;
    logic        src;
    logic [2:0]  flags;
  } res_t;

  logic [CW-1:0]  r_inflight, r_count;
  logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [LAT-1:0] r_vld_pipe, r_src_pipe;
  logic           r_last_w;
  logic [15:0]    r_err_cnt;
  res_t           r_mem [DEPTH];

  logic [CW:0] w_credit;
  logic        w_can_issue, w_cap, w_pop;
  logic [2:0]  w_flags;
  res_t        w_head;

  function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every outstanding issue owns a FIFO slot, so capture can never overflow.
  assign w_credit    = {1'b0, r_inflight} + {1'b0, r_count};
  assign w_can_issue = !rst && (w_credit < (CW+1)'(DEPTH));

  always_comb begin
    w_ready = 1'b0;
    a_ready = 1'b0;
    if (w_can_issue) begin
      if (w_valid && a_valid) begin
        w_ready = !r_last_w;
        a_ready = r_last_w;
      end else begin
        w_ready = w_valid;
        a_ready = a_valid;
      end
    end
  end

  assign dq_issue     = w_ready | a_ready;
  assign dq_level_int = w_ready ? w_level : (a_ready ? a_level : '0);
  assign dq_is_weight = w_ready;

  assign w_cap     = r_vld_pipe[LAT-1];
  assign w_flags   = {dq_ovfl, dq_unfl, dq_excp};
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_head    = r_mem[r_rd_ptr];
  assign out_data  = out_valid ? w_head.data  : '0;
  assign out_src   = out_valid ? w_head.src   : 1'b0;
  assign out_flags = out_valid ? w_head.flags : '0;
  assign busy      = (r_inflight != '0) || out_valid;
  assign err_count = r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_inflight <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_err_cnt  <= '0;
      r_last_w   <= 1'b0;
    end else begin
      r_vld_pipe[0] <= dq_issue;
      r_src_pipe[0] <= dq_is_weight;
      for (int i = 1; i < LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_src_pipe[i] <= r_src_pipe[i-1];
      end
      if (dq_issue) r_last_w <= w_ready;
      if (dq_issue && !w_cap)      r_inflight <= r_inflight + 1'b1;
      else if (!dq_issue && w_cap) r_inflight <= r_inflight - 1'b1;
      if (w_cap) begin
        r_mem[r_wr_ptr] <= '{data: dq_result, src: r_src_pipe[LAT-1], flags: w_flags};
        r_wr_ptr        <= nxt_ptr(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= nxt_ptr(r_rd_ptr);
      if (w_cap && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_cap && w_pop) r_count <= r_count - 1'b1;
      if (w_cap && (|w_flags) && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end
endmodule
